// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the multicycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_DIV  = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_MUL  = 4'b0011,
      OP_OR   = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_SLTU = 4'b1000
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } alu_state_e;

   localparam logic [3:0] ALU_OP_DEFAULT = 4'b1111;

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, XLEN steps after start.
// quotient/remainder present the post-step values, so they are final while done is high.
module alu_seq_divider
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   logic             running;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  dvs;
   logic [XLEN:0]    shifted;
   logic [XLEN:0]    trial;

   assign shifted   = {rem, quo[XLEN-1]};
   assign trial     = shifted - {1'b0, dvs};
   assign quotient  = {quo[XLEN-2:0], ~trial[XLEN]};
   assign remainder = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
   assign done      = running && (cnt == CNT_W'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         running <= 1'b0;
         cnt     <= '0;
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         quo     <= dividend;
         rem     <= '0;
         dvs     <= divisor;
      end else if (running) begin
         quo <= quotient;
         rem <= remainder;
         cnt <= cnt + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops registered in one cycle, iterative signed MUL/DIV.
//   state   | meaning
//   ST_IDLE | waiting for an op, in_ready high
//   ST_MUL  | shift-add multiply, one multiplier bit per cycle
//   ST_DIV  | waiting on the restoring divider
//   ST_DONE | result held with out_valid until out_ready
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int ALUCTRL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      a,
   input  logic [XLEN-1:0]      b,
   input  logic                 cin,
   input  logic [ALUCTRL_W-1:0] alu_ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*XLEN-1:0]    result,
   output logic                 zero,
   output logic                 overflow,
   output logic                 div_by_zero,
   output logic                 busy
);

   localparam int M     = XLEN - 1;
   localparam int CNT_W = $clog2(XLEN) + 1;

   alu_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   mcand;
   logic [2*XLEN-1:0] prod;
   logic              neg_q;
   logic              neg_r;

   logic [XLEN-1:0]   sum, diff, a_mag, b_mag;
   logic              a_min, b_neg1, b_zero, accept, div_start;
   logic [2*XLEN-1:0] sc_res;
   logic              sc_ovf;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] prod_step;
   logic              div_done;
   logic [XLEN-1:0]   div_quo, div_rem, quo_fix, rem_fix;

   assign in_ready = (state == ST_IDLE) && !out_valid;
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid && in_ready;

   assign sum    = a + b + XLEN'(cin);
   assign diff   = a - b;
   assign a_mag  = a[M] ? -a : a;
   assign b_mag  = b[M] ? -b : b;
   assign a_min  = (a == {1'b1, {(XLEN-1){1'b0}}});
   assign b_neg1 = &b;
   assign b_zero = ~|b;

   assign div_start = accept && (alu_ctrl == OP_DIV) && !b_zero && !(a_min && b_neg1);

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (alu_ctrl)
         OP_AND:  sc_res = {{XLEN{1'b0}}, a & b};
         OP_OR:   sc_res = {{XLEN{1'b0}}, a | b};
         OP_XOR:  sc_res = {{XLEN{1'b0}}, a ^ b};
         OP_ADD: begin
            sc_res = {{XLEN{sum[M]}}, sum};
            sc_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
         end
         OP_SUB: begin
            sc_res = {{XLEN{diff[M]}}, diff};
            sc_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
         end
         OP_SLT:  sc_res = {{(2*XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: sc_res = {{(2*XLEN-1){1'b0}}, (a < b)};
         default: ;
      endcase
   end

   // Product register holds {partial high, remaining multiplier bits}; shifts right each step.
   assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
   assign prod_step = {mul_sum, prod[XLEN-1:1]};

   alu_seq_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign quo_fix = neg_q ? -div_quo : div_quo;
   assign rem_fix = neg_r ? -div_rem : div_rem;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         out_valid   <= 1'b0;
         result      <= '0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         mcand       <= '0;
         prod        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               overflow    <= 1'b0;
               div_by_zero <= 1'b0;
               if (alu_ctrl == OP_MUL) begin
                  mcand <= a_mag;
                  prod  <= {{XLEN{1'b0}}, b_mag};
                  neg_q <= a[M] ^ b[M];
                  cnt   <= '0;
                  state <= ST_MUL;
               end else if (alu_ctrl == OP_DIV && b_zero) begin
                  result      <= {a, {XLEN{1'b1}}};
                  zero        <= 1'b0;
                  div_by_zero <= 1'b1;
                  out_valid   <= 1'b1;
                  state       <= ST_DONE;
               end else if (alu_ctrl == OP_DIV && a_min && b_neg1) begin
                  result    <= {{XLEN{1'b0}}, a};
                  zero      <= 1'b0;
                  overflow  <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else if (alu_ctrl == OP_DIV) begin
                  neg_q <= a[M] ^ b[M];
                  neg_r <= a[M];
                  state <= ST_DIV;
               end else begin
                  result    <= sc_res;
                  zero      <= ~|sc_res;
                  overflow  <= sc_ovf;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_MUL: begin
               prod <= prod_step;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(XLEN - 1)) begin
                  result    <= neg_q ? -prod_step : prod_step;
                  zero      <= ~|prod_step;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DIV: if (div_done) begin
               result    <= {rem_fix, quo_fix};
               zero      <= ~|{div_rem, div_quo};
               out_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized bench for alu_multicycle against a plain-arithmetic reference model.
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int XL = 64;
   localparam logic [XL-1:0] MINV = 64'h8000_0000_0000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            cin = 1'b0;
   logic            out_ready = 1'b0;
   logic [XL-1:0]   a = '0;
   logic [XL-1:0]   b = '0;
   logic [3:0]      alu_ctrl = '0;
   logic            in_ready, out_valid, zero, overflow, div_by_zero, busy;
   logic [2*XL-1:0] result;

   alu_multicycle #(.XLEN(XL), .ALUCTRL_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .alu_ctrl    (alu_ctrl),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*XL-1:0] res;
      logic            z;
      logic            ov;
      logic            dz;
      int              lat;
   } exp_t;

   task automatic chk(input string name, input logic [2*XL-1:0] act, input logic [2*XL-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference: exact arithmetic on wide signed values, then apply the width/flag rules.
   function automatic exp_t model(input logic [XL-1:0] ma, input logic [XL-1:0] mb,
                                  input logic mc, input logic [3:0] op);
      exp_t e;
      longint sa, sb;
      logic signed [2*XL-1:0] wa, wb, w;
      sa = ma;
      sb = mb;
      wa = sa;
      wb = sb;
      e.res = '0;
      e.ov  = 1'b0;
      e.dz  = 1'b0;
      e.lat = 1;
      case (op)
         OP_AND:  e.res = {64'd0, ma & mb};
         OP_OR:   e.res = {64'd0, ma | mb};
         OP_XOR:  e.res = {64'd0, ma ^ mb};
         OP_ADD: begin
            w = wa + wb + 128'(mc);
            e.res = {{64{w[63]}}, w[63:0]};
            e.ov  = (w != e.res);
         end
         OP_SUB: begin
            w = wa - wb;
            e.res = {{64{w[63]}}, w[63:0]};
            e.ov  = (w != e.res);
         end
         OP_SLT:  e.res = (sa < sb) ? 128'd1 : 128'd0;
         OP_SLTU: e.res = (ma < mb) ? 128'd1 : 128'd0;
         OP_MUL: begin
            e.res = wa * wb;
            e.lat = XL + 1;
         end
         OP_DIV: begin
            if (mb == '0) begin
               e.res = {ma, {XL{1'b1}}};
               e.dz  = 1'b1;
            end else if (ma == MINV && mb == '1) begin
               e.res = {64'd0, ma};
               e.ov  = 1'b1;
            end else begin
               e.res = {64'(sa % sb), 64'(sa / sb)};
               e.lat = XL + 1;
            end
         end
         default: ;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   bit   inflight = 0;
   bit   rst_prev = 0;
   int   ready_cyc = 0;
   exp_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         inflight = 0;
         rst_prev = 1;
      end else begin
         if (rst_prev) begin
            chk("rst_result", result, '0);
            chk("rst_zero", zero, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_div_by_zero", div_by_zero, 0);
            rst_prev = 0;
         end
         chk("in_ready", in_ready, !inflight);
         chk("busy", busy, inflight);
         chk("out_valid", out_valid, inflight && cyc >= ready_cyc);
         if (inflight && cyc >= ready_cyc) begin
            chk("result", result, cur.res);
            chk("zero", zero, cur.z);
            chk("overflow", overflow, cur.ov);
            chk("div_by_zero", div_by_zero, cur.dz);
            if (out_ready) inflight = 0;
         end else if (!inflight && in_valid) begin
            cur       = model(a, b, cin, alu_ctrl);
            inflight  = 1;
            ready_cyc = cyc + cur.lat;
         end
      end
   end

   task automatic issue(input logic [XL-1:0] ia, input logic [XL-1:0] ib,
                        input logic ic, input logic [3:0] op);
      int  n;
      logic acc;
      n = 0;
      @(posedge clk); #1;
      a = ia; b = ib; cin = ic; alu_ctrl = op; in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 200);
      chk("accept_seen", acc, 1);
      // Garbage while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      alu_ctrl = 4'($urandom_range(0, 15));
   endtask

   task automatic consume(input int hold);
      int  n;
      logic v;
      n = 0;
      do begin
         @(negedge clk);
         v = out_valid;
         n++;
      end while (!v && n < 300);
      chk("result_seen", v, 1);
      @(posedge clk); #1;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [XL-1:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return MINV;
         3:       return ~MINV;
         4:       return 64'($urandom_range(0, 20));
         5:       return -64'($urandom_range(1, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   exp_t e;

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Pin the reference model with hand-computed values.
      e = model(64'd5, -64'sd3, 1'b1, OP_ADD);
      chk("pin_add", e.res, 128'd3);
      e = model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD);
      chk("pin_add_ovf", {e.ov, e.res[63:0]}, {1'b1, 64'h8000_0000_0000_0000});
      e = model(MINV, 64'd1, 1'b0, OP_SUB);
      chk("pin_sub_ovf", e.ov, 1);
      e = model(-64'sd7, 64'd6, 1'b0, OP_MUL);
      chk("pin_mul", {e.res, 32'(e.lat)}, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, 32'd65});
      e = model(-64'sd17, 64'd5, 1'b0, OP_DIV);
      chk("pin_div", e.res, {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD});
      e = model(64'd9, 64'd0, 1'b0, OP_DIV);
      chk("pin_div0", {e.dz, e.res, 32'(e.lat)}, {1'b1, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1});
      e = model(MINV, '1, 1'b0, OP_DIV);
      chk("pin_div_ovf", {e.ov, e.res}, {1'b1, 64'd0, 64'h8000_0000_0000_0000});
      e = model('1, 64'd0, 1'b0, OP_SLT);
      chk("pin_slt", e.res, 128'd1);
      e = model('1, 64'd0, 1'b0, OP_SLTU);
      chk("pin_sltu", e.res, 128'd0);
      e = model(64'd3, 64'd4, 1'b0, ALU_OP_DEFAULT);
      chk("pin_default", {e.z, e.res}, {1'b1, 128'd0});

      // Directed sequence through the DUT.
      issue(64'd5, -64'sd3, 1'b1, OP_ADD);                 consume(0);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD); consume(1);
      issue(MINV, 64'd1, 1'b0, OP_SUB);                    consume(0);
      issue(-64'sd7, 64'd6, 1'b0, OP_MUL);                 consume(3);
      issue(-64'sd17, 64'd5, 1'b0, OP_DIV);                consume(0);
      issue(64'd9, 64'd0, 1'b0, OP_DIV);                   consume(2);
      issue(MINV, '1, 1'b0, OP_DIV);                       consume(0);
      issue('1, 64'd0, 1'b0, OP_SLT);                      consume(0);
      issue('1, 64'd0, 1'b0, OP_SLTU);                     consume(0);
      issue(64'd3, 64'd4, 1'b0, ALU_OP_DEFAULT);           consume(0);

      // Reset during a multiply, then a plain AND.
      issue(64'd123, -64'sd77, 1'b0, OP_MUL);
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      issue(64'hF0, 64'h3C, 1'b0, OP_AND);                 consume(0);

      for (int i = 0; i < 200; i++) begin
         issue(rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         consume($urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
